// File: rtl/integer_digit_mux_driver.sv
// Binary-to-BCD conversion with a sequential double-dabble engine,
// driving a multiplexed seven-segment display from a one-hot digit select.
module integer_digit_mux_driver #(
    parameter int N_DIGITS       = 3,
    parameter int VALUE_WIDTH    = 10,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   value_valid,
    input  logic [VALUE_WIDTH-1:0] value,
    output logic                   value_ready,
    input  logic [N_DIGITS-1:0]    digit_select,
    output logic [N_DIGITS-1:0]    anode,
    output logic [6:0]             segments,
    output logic                   overflow
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam longint unsigned MAX_VAL = longint'(10) ** N_DIGITS - 1;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t                       state_q, state_d;
    logic [VALUE_WIDTH-1:0]       bin_q;
    logic [BCD_W-1:0]             bcd_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         ovf_pend_q;
    logic [N_DIGITS-1:0][3:0]     disp_q;
    logic [BCD_W-1:0]             bcd_adj;
    logic [BCD_W+VALUE_WIDTH-1:0] dd_shift;
    logic [N_DIGITS-1:0][6:0]     pattern;
    logic [6:0]                   sel_pat;
    logic                         sel_onehot;
    logic                         zero_run;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    assign value_ready = (state_q == IDLE);

    // Double-dabble step: correct nibbles >= 5, then shift {bcd, bin} left
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    assign dd_shift = {bcd_adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (value_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(VALUE_WIDTH - 1)) state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            overflow   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (value_valid) begin
                        bin_q      <= value;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        ovf_pend_q <= (64'(value) > MAX_VAL);
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= dd_shift;
                    cnt_q          <= cnt_q + 1'b1;
                end
                LATCH: begin
                    disp_q   <= bcd_q;
                    overflow <= ovf_pend_q;
                end
                default: ;
            endcase
        end
    end

    // Walk from the top digit so zero_run means "this and all higher are 0"
    always_comb begin
        zero_run = 1'b1;
        pattern  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_q[i] == 4'd0);
            if (overflow)
                pattern[i] = 7'h40;
            else if ((BLANK_LEADING != 0) && (i > 0) && zero_run)
                pattern[i] = 7'h00;
            else
                pattern[i] = glyph(disp_q[i]);
        end
    end

    always_comb begin
        sel_pat = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_select[i]) sel_pat = sel_pat | pattern[i];
        end
    end

    assign sel_onehot = (digit_select != '0) &&
                        ((digit_select & (digit_select - 1'b1)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode    <= AN_OFF;
            segments <= SEG_OFF;
        end else if (sel_onehot) begin
            anode    <= (AN_ACTIVE_LOW != 0) ? ~digit_select : digit_select;
            segments <= (SEG_ACTIVE_LOW != 0) ? ~sel_pat : sel_pat;
        end else begin
            anode    <= AN_OFF;
            segments <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_integer_digit_mux_driver.sv
// Directed self-checking bench for integer_digit_mux_driver.
module tb_integer_digit_mux_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       value_valid;
    logic [9:0] value;
    logic       value_ready;
    logic [2:0] digit_select;
    logic [2:0] anode;
    logic [6:0] segments;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int lowc;

    integer_digit_mux_driver #(
        .N_DIGITS(3),
        .VALUE_WIDTH(10),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW(1),
        .BLANK_LEADING(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value_valid(value_valid),
        .value(value),
        .value_ready(value_ready),
        .digit_select(digit_select),
        .anode(anode),
        .segments(segments),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a value in IDLE; returns at the negedge after the accepting edge
    task automatic start(input logic [9:0] v);
        @(negedge clk);
        value       = v;
        value_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    // Count negedges with value_ready low (bounded)
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!value_ready && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 50) check("ready_timeout", 32'(value_ready), 32'd1);
    endtask

    task automatic show(input string tag, input logic [2:0] sel,
                        input logic [2:0] e_an, input logic [6:0] e_seg);
        @(negedge clk);
        digit_select = sel;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_an"}, 32'(anode), 32'(e_an));
        check({tag, "_seg"}, 32'(segments), 32'(e_seg));
    endtask

    initial begin
        rst_n        = 1'b0;
        value_valid  = 1'b0;
        value        = '0;
        digit_select = 3'b001;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(anode), 32'h7);
        check("rst_seg", 32'(segments), 32'h7F);
        check("rst_ready", 32'(value_ready), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        show("rst_d0", 3'b001, 3'b110, 7'h40);
        show("rst_d1", 3'b010, 3'b101, 7'h7F);

        start(10'd427);
        wait_ready(lowc);
        check("busy_427", 32'(lowc), 32'd11);
        show("v427_d0", 3'b001, 3'b110, 7'h78);
        show("v427_d1", 3'b010, 3'b101, 7'h24);
        show("v427_d2", 3'b100, 3'b011, 7'h19);

        start(10'd5);
        wait_ready(lowc);
        show("v5_d0", 3'b001, 3'b110, 7'h12);
        show("v5_d1", 3'b010, 3'b101, 7'h7F);
        show("v5_d2", 3'b100, 3'b011, 7'h7F);

        start(10'd40);
        wait_ready(lowc);
        show("v40_d0", 3'b001, 3'b110, 7'h40);
        show("v40_d1", 3'b010, 3'b101, 7'h19);
        show("v40_d2", 3'b100, 3'b011, 7'h7F);

        start(10'd1000);
        wait_ready(lowc);
        check("v1000_ovf", 32'(overflow), 32'd1);
        show("v1000_d0", 3'b001, 3'b110, 7'h3F);
        show("v1000_d1", 3'b010, 3'b101, 7'h3F);
        show("v1000_d2", 3'b100, 3'b011, 7'h3F);

        start(10'd999);
        check("v999_ovf_hold", 32'(overflow), 32'd1);
        wait_ready(lowc);
        check("busy_999", 32'(lowc), 32'd11);
        check("v999_ovf", 32'(overflow), 32'd0);
        show("v999_d0", 3'b001, 3'b110, 7'h10);
        show("v999_d1", 3'b010, 3'b101, 7'h10);
        show("v999_d2", 3'b100, 3'b011, 7'h10);

        // 123 offered while busy and withdrawn before ready rises
        start(10'd427);
        value       = 10'd123;
        value_valid = 1'b1;
        repeat (6) @(negedge clk);
        value_valid = 1'b0;
        wait_ready(lowc);
        repeat (3) @(negedge clk);
        check("drop_ready", 32'(value_ready), 32'd1);
        show("drop_d0", 3'b001, 3'b110, 7'h78);
        show("drop_d1", 3'b010, 3'b101, 7'h24);
        show("drop_d2", 3'b100, 3'b011, 7'h19);

        show("multi_hot", 3'b011, 3'b111, 7'h7F);
        show("no_sel", 3'b000, 3'b111, 7'h7F);

        // Reset aborts an in-flight conversion
        digit_select = 3'b001;
        start(10'd427);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_an", 32'(anode), 32'h7);
        check("mid_rst_seg", 32'(segments), 32'h7F);
        check("mid_rst_ready", 32'(value_ready), 32'd1);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_ready", 32'(value_ready), 32'd1);
        show("post_rst_d0", 3'b001, 3'b110, 7'h40);
        show("post_rst_d1", 3'b010, 3'b101, 7'h7F);
        show("post_rst_d2", 3'b100, 3'b011, 7'h7F);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
